bp2wb_burst_bridge: RTL and testbench

- Parametrised successor to the single-beat BlackParrot-to-Wishbone adapter. Converts one BP memory command at a time into a Wishbone B4 transaction, then returns one response.
- Cached-region commands become full-block incrementing bursts. Uncached commands become single beats with byte-lane selects derived from size and address.
- Adds configurable bus width, retry, error reporting and a bus-hang timeout. Sits between the BP memory-command port and the LiteX Wishbone interconnect.

---
 rtl/bp2wb_burst_bridge_if.sv | 31 +++
 rtl/bp2wb_burst_bridge.sv | 219 +++++++++++++++++++++
 tb/tb_bp2wb_burst_bridge.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp2wb_burst_bridge_if.sv
// Wishbone B4 bundle between the BP burst bridge and the interconnect.
// Signal names follow the bus master's point of view.
interface bp2wb_burst_bridge_if #(
    parameter int paddr_width_p   = 40,
    parameter int wb_data_width_p = 64
);
    localparam int AW = paddr_width_p - $clog2(wb_data_width_p / 8);

    logic [AW-1:0]                adr_o;
    logic [wb_data_width_p-1:0]   dat_o;
    logic [wb_data_width_p-1:0]   dat_i;
    logic [wb_data_width_p/8-1:0] sel_o;
    logic                         we_o;
    logic                         stb_o;
    logic                         cyc_o;
    logic [2:0]                   cti_o;
    logic [1:0]                   bte_o;
    logic                         ack_i;
    logic                         err_i;
    logic                         rty_i;

    modport master (
        output adr_o, dat_o, sel_o, we_o, stb_o, cyc_o, cti_o, bte_o,
        input  dat_i, ack_i, err_i, rty_i
    );

    modport slave (
        input  adr_o, dat_o, sel_o, we_o, stb_o, cyc_o, cti_o, bte_o,
        output dat_i, ack_i, err_i, rty_i
    );
endinterface

// File: rtl/bp2wb_burst_bridge.sv
// BlackParrot memory command to Wishbone B4 bridge, one command in flight.
// Cached blocks become linear bursts; uncached accesses are single beats.
module bp2wb_burst_bridge #(
    parameter int          paddr_width_p    = 40,
    parameter int          block_width_p    = 512,
    parameter int          wb_data_width_p  = 64,
    parameter int          tag_width_p      = 11,
    parameter logic [63:0] uncached_base_p  = 64'h7000_0000,
    parameter bit          burst_en_p       = 1'b1,
    parameter int          timeout_cycles_p = 1024
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     cmd_v_i,
    output logic                     cmd_ready_o,
    input  logic                     cmd_we_i,
    input  logic [paddr_width_p-1:0] cmd_addr_i,
    input  logic [2:0]               cmd_size_i,
    input  logic [tag_width_p-1:0]   cmd_tag_i,
    input  logic [block_width_p-1:0] cmd_data_i,
    output logic                     resp_v_o,
    input  logic                     resp_yumi_i,
    output logic [block_width_p-1:0] resp_data_o,
    output logic [tag_width_p-1:0]   resp_tag_o,
    output logic                     resp_err_o,
    bp2wb_burst_bridge_if.master     wb
);
    localparam int W     = wb_data_width_p;
    localparam int NB    = W / 8;
    localparam int OFFW  = $clog2(NB);
    localparam int BLK   = block_width_p;
    localparam int BEATS = BLK / W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int AW    = paddr_width_p - OFFW;
    localparam int TW    = $clog2(timeout_cycles_p) + 1;
    localparam int LMW   = 2 * NB;

    localparam logic [paddr_width_p-1:0] UC_BASE =
        paddr_width_p'(uncached_base_p);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        RESP
    } state_e;

    state_e           state_q;
    logic             cached_q;
    logic             we_q;
    logic [OFFW-1:0]  off_q;
    logic [BW-1:0]    beat_q;
    logic [TW-1:0]    to_q;
    logic [BLK-1:0]   wdata_q;
    logic [BLK-1:0]   rdata_q;
    logic [tag_width_p-1:0] tag_q;
    logic             err_q;

    logic             cmd_cached;
    logic             size_ok;
    logic [OFFW-1:0]  cmd_off;
    logic [AW-1:0]    cmd_word;
    logic [AW-1:0]    blk_word;
    logic [LMW-1:0]   len_mask;
    logic [NB-1:0]    uc_sel;
    logic [W-1:0]     uc_wdata;
    logic [W-1:0]     rd_mask;
    logic [W-1:0]     uc_rdata;
    logic [BW-1:0]    beat_nx;
    logic             last_beat;

    always_comb begin
        cmd_cached = cmd_addr_i >= UC_BASE;
        size_ok    = int'(cmd_size_i) <= OFFW;
        cmd_off    = cmd_addr_i[OFFW-1:0];
        cmd_word   = cmd_addr_i[paddr_width_p-1:OFFW];
        blk_word   = cmd_word & ~AW'(BEATS - 1);
        len_mask   = (LMW'(1) << (1 << cmd_size_i)) - LMW'(1);
        uc_sel     = len_mask[NB-1:0] << cmd_off;
        uc_wdata   = cmd_data_i[W-1:0] << {cmd_off, 3'b000};
        beat_nx    = beat_q + BW'(1);
        last_beat  = !cached_q || (beat_q == BW'(BEATS - 1));
    end

    // Uncached reads keep only the selected lanes, right-justified.
    always_comb begin
        rd_mask = '0;
        for (int b = 0; b < NB; b++) begin
            rd_mask[b*8 +: 8] = {8{wb.sel_o[b]}};
        end
        uc_rdata = (wb.dat_i & rd_mask) >> {off_q, 3'b000};
    end

    assign cmd_ready_o = (state_q == IDLE);
    assign resp_v_o    = (state_q == RESP);
    assign resp_data_o = rdata_q;
    assign resp_tag_o  = tag_q;
    assign resp_err_o  = err_q;
    assign wb.bte_o    = 2'b00;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            cached_q  <= 1'b0;
            we_q      <= 1'b0;
            off_q     <= '0;
            beat_q    <= '0;
            to_q      <= '0;
            rdata_q   <= '0;
            tag_q     <= '0;
            err_q     <= 1'b0;
            wb.cyc_o  <= 1'b0;
            wb.stb_o  <= 1'b0;
            wb.we_o   <= 1'b0;
            wb.cti_o  <= 3'b000;
            wb.adr_o  <= '0;
            wb.sel_o  <= '0;
            wb.dat_o  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_v_i) begin
                        tag_q    <= cmd_tag_i;
                        we_q     <= cmd_we_i;
                        cached_q <= cmd_cached;
                        off_q    <= cmd_off;
                        wdata_q  <= cmd_data_i;
                        rdata_q  <= '0;
                        beat_q   <= '0;
                        to_q     <= '0;
                        if (!cmd_cached && !size_ok) begin
                            state_q <= RESP;
                            err_q   <= 1'b1;
                        end else begin
                            state_q  <= XFER;
                            err_q    <= 1'b0;
                            wb.cyc_o <= 1'b1;
                            wb.stb_o <= 1'b1;
                            wb.we_o  <= cmd_we_i;
                            if (cmd_cached) begin
                                wb.adr_o <= blk_word;
                                wb.sel_o <= '1;
                                wb.dat_o <= cmd_data_i[W-1:0];
                                if (!burst_en_p)
                                    wb.cti_o <= 3'b000;
                                else if (BEATS == 1)
                                    wb.cti_o <= 3'b111;
                                else
                                    wb.cti_o <= 3'b010;
                            end else begin
                                wb.adr_o <= cmd_word;
                                wb.sel_o <= uc_sel;
                                wb.dat_o <= uc_wdata;
                                wb.cti_o <= 3'b000;
                            end
                        end
                    end
                end
                XFER: begin
                    if (wb.err_i) begin
                        state_q  <= RESP;
                        err_q    <= 1'b1;
                        rdata_q  <= '0;
                        to_q     <= '0;
                        wb.cyc_o <= 1'b0;
                        wb.stb_o <= 1'b0;
                        wb.we_o  <= 1'b0;
                        wb.cti_o <= 3'b000;
                    end else if (wb.ack_i) begin
                        to_q <= '0;
                        if (!we_q) begin
                            if (cached_q)
                                rdata_q[int'(beat_q)*W +: W] <= wb.dat_i;
                            else
                                rdata_q <= BLK'(uc_rdata);
                        end
                        if (last_beat) begin
                            state_q  <= RESP;
                            wb.cyc_o <= 1'b0;
                            wb.stb_o <= 1'b0;
                            wb.we_o  <= 1'b0;
                            wb.cti_o <= 3'b000;
                        end else begin
                            beat_q   <= beat_nx;
                            wb.adr_o <= wb.adr_o + AW'(1);
                            wb.dat_o <= wdata_q[int'(beat_nx)*W +: W];
                            if (!burst_en_p)
                                wb.cti_o <= 3'b000;
                            else if (beat_nx == BW'(BEATS - 1))
                                wb.cti_o <= 3'b111;
                            else
                                wb.cti_o <= 3'b010;
                        end
                    end else if (wb.rty_i) begin
                        to_q <= '0;
                    end else if (to_q == TW'(timeout_cycles_p - 1)) begin
                        // Slave never answered: abandon the cycle.
                        state_q  <= RESP;
                        err_q    <= 1'b1;
                        rdata_q  <= '0;
                        to_q     <= '0;
                        wb.cyc_o <= 1'b0;
                        wb.stb_o <= 1'b0;
                        wb.we_o  <= 1'b0;
                        wb.cti_o <= 3'b000;
                    end else begin
                        to_q <= to_q + TW'(1);
                    end
                end
                RESP: begin
                    if (resp_yumi_i) begin
                        state_q <= IDLE;
                        err_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bp2wb_burst_bridge.sv
// Bench for bp2wb_burst_bridge: directed plan steps plus random commands
// checked against a word-addressed memory and address/lane arithmetic.
module tb_bp2wb_burst_bridge;
    localparam int PA  = 40;
    localparam int BLK = 512;
    localparam int W   = 64;
    localparam int TGW = 11;
    localparam int TO  = 16;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic             reset_i;
    logic             cmd_v_i, cmd_ready_o, cmd_we_i;
    logic [PA-1:0]    cmd_addr_i;
    logic [2:0]       cmd_size_i;
    logic [TGW-1:0]   cmd_tag_i;
    logic [BLK-1:0]   cmd_data_i;
    logic             resp_v_o, resp_yumi_i, resp_err_o;
    logic [BLK-1:0]   resp_data_o;
    logic [TGW-1:0]   resp_tag_o;

    logic             c32_v, c32_ready, c32_we;
    logic [PA-1:0]    c32_addr;
    logic [2:0]       c32_size;
    logic [TGW-1:0]   c32_tag;
    logic [127:0]     c32_data;
    logic             r32_v, r32_yumi, r32_err;
    logic [127:0]     r32_data;
    logic [TGW-1:0]   r32_tag;

    bp2wb_burst_bridge_if #(.paddr_width_p(PA), .wb_data_width_p(W)) wb ();
    bp2wb_burst_bridge_if #(.paddr_width_p(PA), .wb_data_width_p(32)) wb32 ();

    bp2wb_burst_bridge #(
        .paddr_width_p(PA), .block_width_p(BLK), .wb_data_width_p(W),
        .tag_width_p(TGW), .uncached_base_p(64'h7000_0000),
        .burst_en_p(1'b1), .timeout_cycles_p(TO)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_addr_i(cmd_addr_i), .cmd_size_i(cmd_size_i),
        .cmd_tag_i(cmd_tag_i), .cmd_data_i(cmd_data_i),
        .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i),
        .resp_data_o(resp_data_o), .resp_tag_o(resp_tag_o),
        .resp_err_o(resp_err_o), .wb(wb)
    );

    bp2wb_burst_bridge #(
        .paddr_width_p(PA), .block_width_p(128), .wb_data_width_p(32),
        .tag_width_p(TGW), .uncached_base_p(64'h7000_0000),
        .burst_en_p(1'b1), .timeout_cycles_p(TO)
    ) dut32 (
        .clk_i(clk_i), .reset_i(reset_i),
        .cmd_v_i(c32_v), .cmd_ready_o(c32_ready), .cmd_we_i(c32_we),
        .cmd_addr_i(c32_addr), .cmd_size_i(c32_size),
        .cmd_tag_i(c32_tag), .cmd_data_i(c32_data),
        .resp_v_o(r32_v), .resp_yumi_i(r32_yumi),
        .resp_data_o(r32_data), .resp_tag_o(r32_tag),
        .resp_err_o(r32_err), .wb(wb32)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] mem [longint];

    task automatic check(input string tag, input logic [511:0] obs,
                         input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [63:0] mem_rd(input longint a);
        if (mem.exists(a)) return mem[a];
        return {a[31:0] ^ 32'hA5C3_0000, ~a[31:0]};
    endfunction

    function automatic logic [7:0] exp_sel(input bit cached,
                                           input logic [2:0] size,
                                           input int off);
        int len;
        if (cached) return 8'hFF;
        len = 1 << size;
        return 8'(((1 << len) - 1) << off);
    endfunction

    function automatic logic [63:0] bytemask(input logic [7:0] s);
        logic [63:0] m;
        for (int b = 0; b < 8; b++) m[b*8 +: 8] = {8{s[b]}};
        return m;
    endfunction

    // One command end to end; the bench plays the Wishbone slave.
    task automatic run_cmd(input bit we, input logic [39:0] addr,
                           input logic [2:0] size, input logic [10:0] tag,
                           input logic [511:0] data, input bit rnd,
                           input int rty_n, input int err_at, input bit hang,
                           input int rst_at, input int hold);
        bit cached, legal, e_err, done;
        int n, off, k, lat, ccyc, rtys, idle;
        longint wa;
        logic [7:0] e_sel;
        logic [63:0] e_dat, bm;
        logic [511:0] e_rd;
        cached = (addr >= 40'h70000000);
        off    = int'(addr[2:0]);
        legal  = cached || (size <= 3'd3);
        n      = cached ? BLK / W : 1;
        e_err  = !legal || hang;
        e_rd   = '0;
        k = 0; lat = 1; done = 0; ccyc = 0; rtys = 0; idle = 0;
        check("cmd_ready", 512'(cmd_ready_o), 512'(1));
        cmd_v_i = 1'b1; cmd_we_i = we; cmd_addr_i = addr;
        cmd_size_i = size; cmd_tag_i = tag; cmd_data_i = data;
        tick();
        cmd_v_i = 1'b0;
        while (!resp_v_o && !done && lat < 300) begin
            wb.ack_i = 1'b0; wb.err_i = 1'b0; wb.rty_i = 1'b0;
            resp_yumi_i = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            if (wb.cyc_o) begin
                ccyc++;
                wa = cached ? longint'(addr / 64) * 8 + k : longint'(addr / 8);
                e_sel = exp_sel(cached, size, off);
                e_dat = cached ? data[k*64 +: 64] : 64'(data[63:0] << (8 * off));
                bm = bytemask(e_sel);
                check("stb", 512'(wb.stb_o), 512'(1));
                check("adr", 512'(wb.adr_o), 512'(wa));
                check("sel", 512'(wb.sel_o), 512'(e_sel));
                check("we", 512'(wb.we_o), 512'(we));
                check("cti", 512'(wb.cti_o),
                      512'(!cached ? 3'b000 : (k == n - 1) ? 3'b111 : 3'b010));
                if (we) check("dat_o", 512'(wb.dat_o), 512'(e_dat));
                if (k == rst_at) begin
                    reset_i = 1'b1;
                    tick();
                    reset_i = 1'b0;
                    check("rst_cyc", 512'(wb.cyc_o), 512'(0));
                    check("rst_stb", 512'(wb.stb_o), 512'(0));
                    check("rst_we", 512'(wb.we_o), 512'(0));
                    check("rst_resp_v", 512'(resp_v_o), 512'(0));
                    check("rst_resp_err", 512'(resp_err_o), 512'(0));
                    check("rst_ready", 512'(cmd_ready_o), 512'(1));
                    for (int i = 0; i < 3; i++) begin
                        tick();
                        check("rst_no_resp", 512'(resp_v_o), 512'(0));
                    end
                    done = 1;
                end else if (hang) begin
                    idle++;
                end else if (k == err_at) begin
                    wb.err_i = 1'b1;
                    wb.ack_i = 1'($urandom_range(0, 1));
                    wb.rty_i = 1'($urandom_range(0, 1));
                    e_err = 1;
                end else if (rtys < rty_n) begin
                    wb.rty_i = 1'b1;
                    rtys++; idle = 0;
                end else if (rnd && idle < 3 && $urandom_range(0, 3) == 0) begin
                    idle++;
                end else if (rnd && $urandom_range(0, 4) == 0) begin
                    wb.rty_i = 1'b1;
                    idle = 0;
                end else begin
                    wb.ack_i = 1'b1;
                    wb.rty_i = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                    idle = 0; rtys = 0;
                    if (we) begin
                        mem[wa] = (mem_rd(wa) & ~bm) | (e_dat & bm);
                    end else begin
                        wb.dat_i = mem_rd(wa);
                        if (cached) e_rd[k*64 +: 64] = wb.dat_i;
                        else e_rd = 512'((wb.dat_i & bm) >> (8 * off));
                    end
                    k++;
                end
            end
            if (!done) begin
                tick();
                lat++;
            end
        end
        wb.ack_i = 1'b0; wb.err_i = 1'b0; wb.rty_i = 1'b0;
        resp_yumi_i = 1'b0;
        if (done) return;
        check("resp_v", 512'(resp_v_o), 512'(1));
        check("cyc_in_resp", 512'(wb.cyc_o), 512'(0));
        if (!legal) begin
            check("illegal_no_bus", 512'(ccyc), 512'(0));
            check("illegal_lat", 512'(lat), 512'(1));
        end else if (hang) begin
            check("timeout_cycles", 512'(ccyc), 512'(TO));
        end else begin
            check("beats", 512'(k), 512'((err_at >= 0 && err_at < n) ? err_at : n));
        end
        if (!rnd && rty_n == 0 && !e_err) check("latency", 512'(lat), 512'(n + 1));
        if (e_err || we) e_rd = '0;
        check("resp_err", 512'(resp_err_o), 512'(e_err));
        check("resp_tag", 512'(resp_tag_o), 512'(tag));
        check("resp_data", resp_data_o, e_rd);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_v", 512'(resp_v_o), 512'(1));
            check("hold_ready", 512'(cmd_ready_o), 512'(0));
            check("hold_data", resp_data_o, e_rd);
            check("hold_tag", 512'(resp_tag_o), 512'(tag));
        end
        resp_yumi_i = 1'b1;
        tick();
        resp_yumi_i = 1'b0;
        check("post_v", 512'(resp_v_o), 512'(0));
        check("post_ready", 512'(cmd_ready_o), 512'(1));
    endtask

    initial begin
        logic [511:0] d;
        logic [39:0] a;
        logic [2:0] sz;
        bit rw;
        int ea, nb;
        reset_i = 1'b1;
        cmd_v_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = '0; cmd_size_i = '0;
        cmd_tag_i = '0; cmd_data_i = '0; resp_yumi_i = 1'b0;
        c32_v = 1'b0; c32_we = 1'b0; c32_addr = '0; c32_size = '0;
        c32_tag = '0; c32_data = '0; r32_yumi = 1'b0;
        wb.dat_i = '0; wb.ack_i = 1'b0; wb.err_i = 1'b0; wb.rty_i = 1'b0;
        wb32.dat_i = '0; wb32.ack_i = 1'b0; wb32.err_i = 1'b0; wb32.rty_i = 1'b0;
        repeat (3) tick();
        reset_i = 1'b0;
        tick();
        check("reset_cyc", 512'(wb.cyc_o), 512'(0));
        check("reset_stb", 512'(wb.stb_o), 512'(0));
        check("reset_we", 512'(wb.we_o), 512'(0));
        check("reset_resp_v", 512'(resp_v_o), 512'(0));
        check("reset_resp_err", 512'(resp_err_o), 512'(0));
        check("reset_ready", 512'(cmd_ready_o), 512'(1));

        for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom;
        run_cmd(1'b0, 40'h80000040, 3'd6, 11'h155, d, 1'b0, 0, -1, 1'b0, -1, 0);
        d = '0;
        d[15:0] = 16'hBEEF;
        run_cmd(1'b1, 40'h40000006, 3'd1, 11'h0A2, d, 1'b0, 0, -1, 1'b0, -1, 0);
        mem[64'h0800_0000] = 64'h1234_5678_9ABC_DEF0;
        run_cmd(1'b0, 40'h40000004, 3'd2, 11'h033, d, 1'b0, 2, -1, 1'b0, -1, 0);
        for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom;
        run_cmd(1'b1, 40'h80001000, 3'd6, 11'h7E1, d, 1'b0, 0, 3, 1'b0, -1, 0);
        run_cmd(1'b0, 40'h80002000, 3'd6, 11'h444, d, 1'b0, 0, -1, 1'b1, -1, 0);
        run_cmd(1'b0, 40'h80003000, 3'd6, 11'h111, d, 1'b0, 0, -1, 1'b0, 4, 0);
        run_cmd(1'b0, 40'h40000100, 3'd3, 11'h2C2, d, 1'b0, 0, -1, 1'b0, -1, 5);
        run_cmd(1'b0, 40'h40000108, 3'd4, 11'h019, d, 1'b0, 0, -1, 1'b0, -1, 0);

        c32_v = 1'b1; c32_we = 1'b0; c32_addr = 40'h40000010;
        c32_size = 3'd3; c32_tag = 11'h3A5;
        tick();
        c32_v = 1'b0;
        check("w32_ill_cyc", 512'(wb32.cyc_o), 512'(0));
        check("w32_ill_v", 512'(r32_v), 512'(1));
        check("w32_ill_err", 512'(r32_err), 512'(1));
        check("w32_ill_tag", 512'(r32_tag), 512'(11'h3A5));
        check("w32_ill_data", 512'(r32_data), 512'(0));
        r32_yumi = 1'b1;
        tick();
        r32_yumi = 1'b0;
        check("w32_ready", 512'(c32_ready), 512'(1));
        c32_v = 1'b1; c32_size = 3'd2; c32_tag = 11'h05A;
        tick();
        c32_v = 1'b0;
        check("w32_cyc", 512'(wb32.cyc_o), 512'(1));
        check("w32_adr", 512'(wb32.adr_o), 512'(38'h10000004));
        check("w32_sel", 512'(wb32.sel_o), 512'(4'hF));
        wb32.ack_i = 1'b1;
        wb32.dat_i = 32'hCAFE_F00D;
        tick();
        wb32.ack_i = 1'b0;
        check("w32_v", 512'(r32_v), 512'(1));
        check("w32_err", 512'(r32_err), 512'(0));
        check("w32_data", 512'(r32_data), 512'(32'hCAFE_F00D));
        r32_yumi = 1'b1;
        tick();
        r32_yumi = 1'b0;

        for (int t = 0; t < 40; t++) begin
            rw = 1'($urandom_range(0, 1));
            for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                a = 40'h80000000 + 40'($urandom_range(0, 63)) * 40'd64
                    + 40'($urandom_range(0, 63));
                sz = 3'd6;
                ea = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1;
            end else if ($urandom_range(0, 9) == 0) begin
                sz = 3'($urandom_range(4, 7));
                a = 40'h40000000 + 40'($urandom_range(0, 2047));
                ea = -1;
            end else begin
                sz = 3'($urandom_range(0, 3));
                nb = 1 << sz;
                a = 40'h40000000 + 40'($urandom_range(0, 255)) * 40'd8
                    + 40'($urandom_range(0, 8 / nb - 1) * nb);
                ea = ($urandom_range(0, 7) == 0) ? 0 : -1;
            end
            run_cmd(rw, a, sz, 11'($urandom), d, 1'b1, 0, ea, 1'b0, -1,
                    int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
